// File: rtl/choreo_pkg.sv
// Shared types and constants for the choreography playback controller.
package choreo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    PAT_KNIGHT  = 3'b000,
    PAT_WALK    = 3'b001,
    PAT_EXPAND  = 3'b010,
    PAT_BLINK   = 3'b011,
    PAT_ALT     = 3'b100,
    PAT_MARQUEE = 3'b101,
    PAT_SPARKLE = 3'b110,
    PAT_OFF     = 3'b111
  } pattern_t;

  // Entry layout is {pattern, speed, duration}; offsets are relative to the duration width.
  localparam int PAT_W   = 3;
  localparam int HDR_W   = 4;
  localparam int SPD_OFS = 0;
  localparam int PAT_OFS = 1;

  function automatic int entry_w(input int dur_w);
    return dur_w + HDR_W;
  endfunction

endpackage

// File: rtl/choreo_playlist_ram.sv
// Playlist register file: synchronous write, combinational read, cleared on reset.
module choreo_playlist_ram
  import choreo_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int EW    = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [EW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [EW-1:0] rd_data
);

  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/choreo_sequencer.sv
// Playlist-driven playback controller feeding the LED pattern generator's
// pattern/speed/pause inputs, advancing one step per programmed beat count.
module choreo_sequencer
  import choreo_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int DUR_W = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DUR_W+3:0] wr_data,
  input  logic [AW:0]      len,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  output logic [2:0]       pat_sel,
  output logic             speed_sel,
  output logic             pause,
  output logic [AW-1:0]    step_idx,
  output logic             busy,
  output logic             done
);

  localparam int         EW      = entry_w(DUR_W);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t         state, state_nxt;
  logic [AW-1:0]  idx_q, idx_nxt;
  logic [DUR_W-1:0] timer_q, timer_nxt;
  logic [AW:0]    len_q, len_nxt;
  logic           loop_q, loop_nxt;
  pattern_t       pat_q, pat_nxt;
  logic           spd_q, spd_nxt;
  logic           pause_q, pause_nxt;
  logic           done_q, done_nxt;

  logic [AW-1:0]  rd_addr;
  logic [EW-1:0]  rd_data;
  logic [AW:0]    idx_inc;
  logic [AW:0]    len_clamp;
  logic           at_last;
  logic           restart;
  pattern_t       ld_pat;
  logic           ld_spd;
  logic [DUR_W-1:0] ld_dur;

  choreo_playlist_ram #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign idx_inc   = {1'b0, idx_q} + (AW+1)'(1);
  assign at_last   = (idx_inc >= len_q);
  assign restart   = start && !stop && (len != '0);
  assign len_clamp = (len > DEPTH_L) ? DEPTH_L : len;

  // The read port addresses whatever entry would be loaded this cycle, so the
  // load lands in the output registers together with the state change.
  assign rd_addr = (restart || at_last) ? '0 : idx_inc[AW-1:0];

  assign ld_pat = pattern_t'(rd_data[DUR_W+PAT_OFS +: PAT_W]);
  assign ld_spd = rd_data[DUR_W+SPD_OFS];
  assign ld_dur = rd_data[DUR_W-1:0];

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    timer_nxt = timer_q;
    len_nxt   = len_q;
    loop_nxt  = loop_q;
    pat_nxt   = pat_q;
    spd_nxt   = spd_q;
    pause_nxt = pause_q;
    done_nxt  = 1'b0;

    if (stop) begin
      if (state != ST_IDLE) begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
        timer_nxt = '0;
        pat_nxt   = PAT_OFF;
        spd_nxt   = 1'b0;
        pause_nxt = 1'b0;
      end
    end else if (restart) begin
      state_nxt = ST_PLAY;
      len_nxt   = len_clamp;
      loop_nxt  = loop;
      idx_nxt   = '0;
      pat_nxt   = ld_pat;
      spd_nxt   = ld_spd;
      timer_nxt = ld_dur;
      pause_nxt = 1'b0;
    end else begin
      case (state)
        ST_PLAY: begin
          if (hold) begin
            state_nxt = ST_HOLD;
            pause_nxt = 1'b1;
          end else if (tick) begin
            if (timer_q != '0) begin
              timer_nxt = timer_q - DUR_W'(1);
            end else if (!at_last || loop_q) begin
              idx_nxt   = at_last ? '0 : idx_inc[AW-1:0];
              pat_nxt   = ld_pat;
              spd_nxt   = ld_spd;
              timer_nxt = ld_dur;
            end else begin
              state_nxt = ST_IDLE;
              idx_nxt   = '0;
              pat_nxt   = PAT_OFF;
              spd_nxt   = 1'b0;
              done_nxt  = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // A tick arriving as hold falls is dropped; the step resumes next cycle.
          if (!hold) begin
            state_nxt = ST_PLAY;
            pause_nxt = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      pat_q   <= PAT_OFF;
      spd_q   <= 1'b0;
      pause_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx_q   <= idx_nxt;
      timer_q <= timer_nxt;
      len_q   <= len_nxt;
      loop_q  <= loop_nxt;
      pat_q   <= pat_nxt;
      spd_q   <= spd_nxt;
      pause_q <= pause_nxt;
      done_q  <= done_nxt;
    end
  end

  assign pat_sel   = pat_q;
  assign speed_sel = spd_q;
  assign pause     = pause_q;
  assign step_idx  = idx_q;
  assign busy      = (state != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_choreo_sequencer.sv
// Scoreboard bench for choreo_sequencer: per-cycle stimulus and expected outputs
// are queued together, then drained one clock at a time.
module tb_choreo_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] len = '0;
  logic       loop = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] pat_sel;
  logic       speed_sel;
  logic       pause;
  logic [2:0] step_idx;
  logic       busy;
  logic       done;
  logic [9:0] obs;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         rs, tk, hd, st, sp, we;
    logic [3:0] ln;
    bit         lp;
    logic [2:0] wa;
    logic [7:0] wd;
  } stim_t;

  typedef struct {
    string      tag;
    logic [9:0] v;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  always #5 clk = ~clk;

  choreo_sequencer #(.DEPTH(8), .DUR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .len       (len),
    .loop      (loop),
    .start     (start),
    .stop      (stop),
    .hold      (hold),
    .pat_sel   (pat_sel),
    .speed_sel (speed_sel),
    .pause     (pause),
    .step_idx  (step_idx),
    .busy      (busy),
    .done      (done)
  );

  assign obs = {pat_sel, speed_sel, pause, step_idx, busy, done};

  // Queue one cycle: inputs, then the outputs required one clock later
  // as {pat, speed, pause, idx, busy, done}.
  task automatic add(input string tag, input bit rs, tk, hd, st, sp,
                     input logic [3:0] ln, input bit lp,
                     input logic [2:0] p, input bit s, pa,
                     input logic [2:0] i, input bit b, d);
    stim_t x;
    x = '{rs:rs, tk:tk, hd:hd, st:st, sp:sp, we:1'b0, ln:ln, lp:lp, wa:3'd0, wd:8'd0};
    stim_q.push_back(x);
    exp_q.push_back('{tag, {p, s, pa, i, b, d}});
  endtask

  task automatic add_wr(input string tag, input logic [2:0] wa, input logic [7:0] wd,
                        input logic [2:0] p, input bit s, pa,
                        input logic [2:0] i, input bit b, d);
    stim_t x;
    x = '{rs:1'b0, tk:1'b0, hd:1'b0, st:1'b0, sp:1'b0, we:1'b1, ln:4'd2, lp:1'b1, wa:wa, wd:wd};
    stim_q.push_back(x);
    exp_q.push_back('{tag, {p, s, pa, i, b, d}});
  endtask

  task automatic apply(input stim_t x);
    rst = x.rs; tick = x.tk; hold = x.hd; start = x.st; stop = x.sp;
    len = x.ln; loop = x.lp;
    wr_en = x.we; wr_addr = x.wa; wr_data = x.wd;
    @(posedge clk); #1;
    rst = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [2:0] p, input bit s, input logic [3:0] dur);
    wr_en = 1'b1; wr_addr = a; wr_data = {p, s, dur};
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    stim_t x; exp_t e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    add("rst_state",  1,0,0,0,0, 4'd0,0, 3'b111,0,0,3'd0,0,0);
    add("start_len0", 0,0,0,1,0, 4'd0,0, 3'b111,0,0,3'd0,0,0);
    add("idle_stays", 0,1,0,0,0, 4'd0,0, 3'b111,0,0,3'd0,0,0);
    while (stim_q.size() > 0) begin
      x = stim_q.pop_front(); apply(x); e = exp_q.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.tag, obs, e.v); end
    end
  endtask

  task automatic test_one_shot();
    stim_t x; exp_t e;
    wr(3'd0, 3'b000, 1'b0, 4'd1);
    wr(3'd1, 3'b011, 1'b1, 4'd0);
    add("os_start", 0,0,0,1,0, 4'd2,0, 3'b000,0,0,3'd0,1,0);
    add("os_t1",    0,1,0,0,0, 4'd2,0, 3'b000,0,0,3'd0,1,0);
    add("os_gap1",  0,0,0,0,0, 4'd2,0, 3'b000,0,0,3'd0,1,0);
    add("os_t2",    0,1,0,0,0, 4'd2,0, 3'b011,1,0,3'd1,1,0);
    add("os_gap2",  0,0,0,0,0, 4'd2,0, 3'b011,1,0,3'd1,1,0);
    add("os_done",  0,1,0,0,0, 4'd2,0, 3'b111,0,0,3'd0,0,1);
    add("os_after", 0,0,0,0,0, 4'd2,0, 3'b111,0,0,3'd0,0,0);
    while (stim_q.size() > 0) begin
      x = stim_q.pop_front(); apply(x); e = exp_q.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.tag, obs, e.v); end
    end
  endtask

  task automatic test_loop();
    stim_t x; exp_t e;
    add("lp_start", 0,0,0,1,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add("lp_t1",    0,1,0,0,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add("lp_t2",    0,1,0,0,0, 4'd2,1, 3'b011,1,0,3'd1,1,0);
    add("lp_t3",    0,1,0,0,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add("lp_t4",    0,1,0,0,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add("lp_t5",    0,1,0,0,0, 4'd2,1, 3'b011,1,0,3'd1,1,0);
    add("lp_t6",    0,1,0,0,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add("lp_t7",    0,1,0,0,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add("lp_stop",  0,0,0,0,1, 4'd2,1, 3'b111,0,0,3'd0,0,0);
    add("lp_idle",  0,0,0,0,0, 4'd2,1, 3'b111,0,0,3'd0,0,0);
    while (stim_q.size() > 0) begin
      x = stim_q.pop_front(); apply(x); e = exp_q.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.tag, obs, e.v); end
    end
  endtask

  task automatic test_hold();
    stim_t x; exp_t e;
    add("hd_start", 0,0,0,1,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add("hd_t1",    0,1,0,0,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add("hd_rise",  0,0,1,0,0, 4'd2,1, 3'b000,0,1,3'd0,1,0);
    for (int k = 0; k < 5; k++)
      add("hd_frozen", 0,1,1,0,0, 4'd2,1, 3'b000,0,1,3'd0,1,0);
    add("hd_fall_tick", 0,1,0,0,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add("hd_advance",   0,1,0,0,0, 4'd2,1, 3'b011,1,0,3'd1,1,0);
    add("hd_stop",      0,0,0,0,1, 4'd2,1, 3'b111,0,0,3'd0,0,0);
    while (stim_q.size() > 0) begin
      x = stim_q.pop_front(); apply(x); e = exp_q.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.tag, obs, e.v); end
    end
  endtask

  task automatic test_priority();
    stim_t x; exp_t e;
    add("pr_start",     0,0,0,1,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add("pr_t1",        0,1,0,0,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add("pr_t2",        0,1,0,0,0, 4'd2,1, 3'b011,1,0,3'd1,1,0);
    add("pr_startstop", 0,0,0,1,1, 4'd2,1, 3'b111,0,0,3'd0,0,0);
    add("pr_nodone",    0,0,0,0,0, 4'd2,1, 3'b111,0,0,3'd0,0,0);
    add("pr_start2",    0,0,0,1,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add("pr_t3",        0,1,0,0,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add("pr_t4",        0,1,0,0,0, 4'd2,1, 3'b011,1,0,3'd1,1,0);
    add("pr_restart",   0,0,0,1,0, 4'd1,0, 3'b000,0,0,3'd0,1,0);
    add("pr_t5",        0,1,0,0,0, 4'd1,0, 3'b000,0,0,3'd0,1,0);
    add("pr_len1_done", 0,1,0,0,0, 4'd1,0, 3'b111,0,0,3'd0,0,1);
    add("pr_idle",      0,0,0,0,0, 4'd1,0, 3'b111,0,0,3'd0,0,0);
    add("pr_start3",    0,0,0,1,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add("pr_hold",      0,0,1,0,0, 4'd2,1, 3'b000,0,1,3'd0,1,0);
    add("pr_start_hold",0,0,1,1,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add("pr_rehold",    0,0,1,0,0, 4'd2,1, 3'b000,0,1,3'd0,1,0);
    add("pr_stop_hold", 0,0,1,0,1, 4'd2,1, 3'b111,0,0,3'd0,0,0);
    while (stim_q.size() > 0) begin
      x = stim_q.pop_front(); apply(x); e = exp_q.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.tag, obs, e.v); end
    end
  endtask

  task automatic test_live_write();
    stim_t x; exp_t e;
    wr(3'd0, 3'b000, 1'b0, 4'd1);
    wr(3'd1, 3'b011, 1'b1, 4'd0);
    add("lw_start",  0,0,0,1,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add_wr("lw_write", 3'd0, {3'b101, 1'b0, 4'd1}, 3'b000,0,0,3'd0,1,0);
    add("lw_t1",     0,1,0,0,0, 4'd2,1, 3'b000,0,0,3'd0,1,0);
    add("lw_t2",     0,1,0,0,0, 4'd2,1, 3'b011,1,0,3'd1,1,0);
    add("lw_reload", 0,1,0,0,0, 4'd2,1, 3'b101,0,0,3'd0,1,0);
    add("lw_stop",   0,0,0,0,1, 4'd2,1, 3'b111,0,0,3'd0,0,0);
    while (stim_q.size() > 0) begin
      x = stim_q.pop_front(); apply(x); e = exp_q.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.tag, obs, e.v); end
    end
  endtask

  task automatic test_reset_mid();
    stim_t x; exp_t e;
    add("rm_start",   0,0,0,1,0, 4'd2,1, 3'b101,0,0,3'd0,1,0);
    add("rm_t1",      0,1,0,0,0, 4'd2,1, 3'b101,0,0,3'd0,1,0);
    add("rm_rst",     1,1,0,1,0, 4'd2,1, 3'b111,0,0,3'd0,0,0);
    add("rm_cleared", 0,0,0,1,0, 4'd2,0, 3'b000,0,0,3'd0,1,0);
    add("rm_t2",      0,1,0,0,0, 4'd2,0, 3'b000,0,0,3'd1,1,0);
    add("rm_done",    0,1,0,0,0, 4'd2,0, 3'b111,0,0,3'd0,0,1);
    while (stim_q.size() > 0) begin
      x = stim_q.pop_front(); apply(x); e = exp_q.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.tag, obs, e.v); end
    end
  endtask

  task automatic test_len_clamp();
    stim_t x; exp_t e;
    logic [2:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      wr(a, a, a[0], 4'd0);
    end
    add("cl_start", 0,0,0,1,0, 4'd15,0, 3'b000,0,0,3'd0,1,0);
    for (int i = 1; i < 8; i++) begin
      a = 3'(i);
      add("cl_step", 0,1,0,0,0, 4'd15,0, a,a[0],0,a,1,0);
    end
    add("cl_done", 0,1,0,0,0, 4'd15,0, 3'b111,0,0,3'd0,0,1);
    while (stim_q.size() > 0) begin
      x = stim_q.pop_front(); apply(x); e = exp_q.pop_front(); total++;
      if (obs !== e.v) begin bad++; $display("FAIL %s got=%b want=%b", e.tag, obs, e.v); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_one_shot();
    test_loop();
    test_hold();
    test_priority();
    test_live_write();
    test_reset_mid();
    test_len_clamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
